feature_bank_pingpong: RTL and testbench
========================================

# feature_bank_pingpong

Double-buffered, multi-channel feature-map store for the squeeze/expand datapath. It holds CHANNELS parallel lanes of DATA_W-bit words in two copies (side A and side B). The producing layer writes one side while the consuming layer reads the other, and a swap handshake exchanges the roles at a layer boundary. Compared with the single-copy bank it adds:
- a registered read with a valid strobe
- per-channel write masking
- address range checking with a sticky error flag
- a per-side write counter

## Interface
- DATA_W, 16, bits per channel word
- CHANNELS, 8, parallel lanes (banks) per side
- DEPTH, 12321, words per channel per side (111*111)
- ADDR_W, 32, address port width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wren  in  1  write enable (write side)
- wr_mask  in  CHANNELS  per-channel write enable; bit i gates lane i
- address1  in  ADDR_W  write address
- datain  in  DATA_W*CHANNELS  write data; lane i = datain[i*DATA_W +: DATA_W]
- rden  in  1  read enable (read side)
- address2  in  ADDR_W  read address
- dataout  out  DATA_W*CHANNELS  registered read data, same lane packing
- rd_valid  out  1  dataout valid this cycle
- swap_req  in  1  request exchange of write and read sides
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- sel  out  1  0: write side A, read side B; 1: write side B, read side A
- wr_count  out  ADDR_W  accepted in-range writes to the current write side since the last swap
- err  out  1  sticky; set by any out-of-range access

## Operation
- Storage is 2 × CHANNELS arrays of DEPTH × DATA_W. Memory contents are not reset.
- **Write:** when wren=1 and address1 < DEPTH, each lane i with wr_mask[i]=1 writes to the write side at address1.
  - wr_count increments by 1 if wr_mask ≠ 0.
  - Masked-off lanes keep their old value.
- **Out-of-range write** (address1 ≥ DEPTH): no write, wr_count unchanged, err set.
- **Read:** when rden=1, the read side at address2 is sampled and dataout is registered next cycle with rd_valid=1.
  - If address2 ≥ DEPTH: dataout = 0, rd_valid = 1, err set.
  - When rden=0: rd_valid = 0 and dataout holds its last value.
- **Swap, two states:**
  - IDLE: swap_req=1 → SWAP.
  - SWAP, always one cycle: sel toggles, wr_count clears to 0, swap_ack=1, then return to IDLE.
  - swap_req is ignored while in SWAP.
  - swap_req held high gives one swap every 2 cycles.
- **Simultaneous events:**
  - wren/rden in the cycle swap_req is sampled use the old sel.
  - wren/rden during the SWAP cycle also use the old sel; sel changes at the end of that cycle.
  - A write in the SWAP cycle is counted, then wr_count clears. Clearing wins, so wr_count = 0 after the swap.
- Write and read always target opposite sides, so there is no read/write collision for any address pair.
- err clears only on reset.

## Timing
- Reset (rst=0, asynchronous): dataout=0, rd_valid=0, sel=0, swap_ack=0, wr_count=0, err=0, FSM=IDLE.
- Reset deassertion is synchronised internally. The first access is honoured on the second rising edge after rst rises.
- Write latency: data is visible on the other side's reads after the swap completes. A read issued in the cycle after swap_ack returns the new data.
- Read latency: 1 cycle (rden at edge N → dataout/rd_valid after edge N+1). Back-to-back reads give one result per cycle.
- Swap latency: swap_req sampled at edge N → swap_ack high and sel toggled after edge N+1.
- Reset mid-swap aborts the swap: sel returns to 0 and swap_ack stays 0.

## Test plan
- **Write, swap, read:** write lanes 0..7 = 0x0010+i at addr 5 (mask 0xFF), swap, then rden addr 5 → one cycle later dataout lanes = 0x0010..0x0017, rd_valid=1, sel=1, wr_count reads 1 before the swap and 0 after.
- **Mask:** write 0xAAAA all lanes at addr 0, then 0x5555 with mask 0x0F, swap, read addr 0 → lanes 0–3 = 0x5555, lanes 4–7 = 0xAAAA.
- **Range:** write at addr 12321 → no change, err=1, wr_count unchanged; read addr 12321 → dataout=0, rd_valid=1, err stays 1.
- **Swap collision:** wren at addr 7 in the same cycle as swap_req and in the SWAP cycle → both writes land in side A, sel=1 afterwards, wr_count=0; the following read addr 7 returns the second write.
- **Back-to-back reads:** rden for 4 consecutive cycles at addrs 0..3 → rd_valid high 4 cycles, data in order; swap_req held 4 cycles → 2 swap_ack pulses, sel back to its original value.
- **Reset mid-operation:** assert rst low during the SWAP cycle with rd_valid=1 → all outputs return to reset values immediately; sel=0 after release.

Source files
------------

// File: rtl/feature_bank_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : feature_bank_pingpong
// Brief    : Double-buffered CHANNELS-lane feature-map store. One side takes
//            writes while the other is read; a swap handshake exchanges them.
//            Registered read with valid strobe, per-lane write mask, range
//            checking with a sticky error flag, per-side write counter.
// Revision : 1.0 - initial release
// ============================================================================
module feature_bank_pingpong #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 12321,
    parameter int ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wren,
    input  logic [CHANNELS-1:0]        wr_mask,
    input  logic [ADDR_W-1:0]          address1,
    input  logic [DATA_W*CHANNELS-1:0] datain,
    input  logic                       rden,
    input  logic [ADDR_W-1:0]          address2,
    output logic [DATA_W*CHANNELS-1:0] dataout,
    output logic                       rd_valid,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       sel,
    output logic [ADDR_W-1:0]          wr_count,
    output logic                       err
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SWAP = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_run;
    logic                r_sel;
    logic                r_swap_ack;
    logic [ADDR_W-1:0]   r_wr_count;
    logic                r_rd_valid;
    logic                r_err;

    logic                w_wr_in_range;
    logic                w_rd_in_range;
    logic                w_wr_ok;
    logic                w_wr_oor;
    logic                w_rd_en;
    logic                w_rd_oor;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_rd_idx;

    // Access qualification; accesses are blocked until the reset release has
    // been seen by the clock domain.
    assign w_wr_in_range = (address1 < c_DEPTH);
    assign w_rd_in_range = (address2 < c_DEPTH);
    assign w_wr_ok       = wren & r_run & w_wr_in_range;
    assign w_wr_oor      = wren & r_run & ~w_wr_in_range;
    assign w_rd_en       = rden & r_run;
    assign w_rd_oor      = w_rd_en & ~w_rd_in_range;
    assign w_wr_idx      = address1[IDX_W-1:0];
    assign w_rd_idx      = address2[IDX_W-1:0];

    // Reset release retimed to the clock: the first edge after rst rises arms
    // the block, so the second edge is the first to honour an access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_run <= 1'b0;
        else      r_run <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [DATA_W-1:0] r_mem_a [DEPTH];
            logic [DATA_W-1:0] r_mem_b [DEPTH];
            logic [DATA_W-1:0] r_lane_q;

            // Lane write into whichever side is currently the write side.
            always_ff @(posedge clk) begin
                if (w_wr_ok && wr_mask[gi]) begin
                    if (r_sel) r_mem_b[w_wr_idx] <= datain[gi*DATA_W +: DATA_W];
                    else       r_mem_a[w_wr_idx] <= datain[gi*DATA_W +: DATA_W];
                end
            end

            // Registered lane read from the opposite side; out-of-range reads
            // return zero, idle cycles hold the last value.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_lane_q <= '0;
                end else if (w_rd_en) begin
                    if (!w_rd_in_range) r_lane_q <= '0;
                    else if (r_sel)     r_lane_q <= r_mem_a[w_rd_idx];
                    else                r_lane_q <= r_mem_b[w_rd_idx];
                end
            end

            assign dataout[gi*DATA_W +: DATA_W] = r_lane_q;
        end
    endgenerate

    // Read strobe and sticky range error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            r_err      <= r_err | w_wr_oor | w_rd_oor;
        end
    end

    // Swap FSM with write counter; the clear in SWAP is placed last so it
    // overrides a write counted in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_swap_ack <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_swap_ack <= 1'b0;
            if (w_wr_ok && (|wr_mask)) r_wr_count <= r_wr_count + ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (swap_req && r_run) r_state <= S_SWAP;
                end
                S_SWAP: begin
                    r_sel      <= ~r_sel;
                    r_swap_ack <= 1'b1;
                    r_wr_count <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign swap_ack = r_swap_ack;
    assign sel      = r_sel;
    assign wr_count = r_wr_count;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_feature_bank_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_bank_pingpong
// Brief    : Directed self-checking bench for feature_bank_pingpong.
// Revision : 1.0 - initial release
// ============================================================================
module tb_feature_bank_pingpong;

    localparam int DW = 16;
    localparam int CH = 8;
    localparam int AW = 32;
    localparam int DEPTH = 12321;

    logic              clk;
    logic              rst;
    logic              wren;
    logic [CH-1:0]     wr_mask;
    logic [AW-1:0]     address1;
    logic [DW*CH-1:0]  datain;
    logic              rden;
    logic [AW-1:0]     address2;
    logic [DW*CH-1:0]  dataout;
    logic              rd_valid;
    logic              swap_req;
    logic              swap_ack;
    logic              sel;
    logic [AW-1:0]     wr_count;
    logic              err;

    int checks;
    int failures;

    feature_bank_pingpong #(
        .DATA_W(DW), .CHANNELS(CH), .DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .wren(wren), .wr_mask(wr_mask),
        .address1(address1), .datain(datain), .rden(rden),
        .address2(address2), .dataout(dataout), .rd_valid(rd_valid),
        .swap_req(swap_req), .swap_ack(swap_ack), .sel(sel),
        .wr_count(wr_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*CH-1:0] ramp(input logic [DW-1:0] base);
        logic [DW*CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i*DW +: DW] = base + DW'(i);
        return v;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [CH-1:0] m,
                            input logic [DW*CH-1:0] d);
        wren = 1'b1; address1 = a; wr_mask = m; datain = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        if ({dataout, rd_valid, swap_ack, sel, wr_count, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got dout=%h v=%b ack=%b sel=%b cnt=%0d err=%b expected all zero",
                     dataout, rd_valid, swap_ack, sel, wr_count, err);
        end
        checks++;
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_write_swap_read();
        do_write(32'd5, 8'hFF, ramp(16'h0010));
        if (wr_count !== 32'd1) begin
            failures++; $display("FAIL wsr_count_before: got %0d expected 1", wr_count);
        end
        checks++;
        do_swap();
        if (swap_ack !== 1'b1 || sel !== 1'b1) begin
            failures++; $display("FAIL wsr_swap: got ack=%b sel=%b expected ack=1 sel=1", swap_ack, sel);
        end
        checks++;
        if (wr_count !== 32'd0) begin
            failures++; $display("FAIL wsr_count_after: got %0d expected 0", wr_count);
        end
        checks++;
        rden = 1'b1; address2 = 32'd5;
        tick();
        rden = 1'b0;
        if (dataout !== ramp(16'h0010) || rd_valid !== 1'b1) begin
            failures++; $display("FAIL wsr_read: got %h v=%b expected %h v=1", dataout, rd_valid, ramp(16'h0010));
        end
        checks++;
        tick();
        if (rd_valid !== 1'b0 || dataout !== ramp(16'h0010)) begin
            failures++; $display("FAIL wsr_hold: got %h v=%b expected %h v=0", dataout, rd_valid, ramp(16'h0010));
        end
        checks++;
    endtask

    task automatic test_mask();
        logic [DW*CH-1:0] exp_d;
        do_write(32'd0, 8'hFF, {CH{16'hAAAA}});
        do_write(32'd0, 8'h0F, {CH{16'h5555}});
        if (wr_count !== 32'd2) begin
            failures++; $display("FAIL mask_count: got %0d expected 2", wr_count);
        end
        checks++;
        do_swap();
        if (sel !== 1'b0) begin
            failures++; $display("FAIL mask_sel: got %b expected 0", sel);
        end
        checks++;
        exp_d = {{4{16'hAAAA}}, {4{16'h5555}}};
        rden = 1'b1; address2 = 32'd0;
        tick();
        rden = 1'b0;
        if (dataout !== exp_d) begin
            failures++; $display("FAIL mask_read: got %h expected %h", dataout, exp_d);
        end
        checks++;
    endtask

    task automatic test_range();
        if (err !== 1'b0) begin
            failures++; $display("FAIL range_err_pre: got %b expected 0", err);
        end
        checks++;
        do_write(32'd12321, 8'hFF, {CH{16'h1234}});
        if (err !== 1'b1 || wr_count !== 32'd0) begin
            failures++; $display("FAIL range_write: got err=%b cnt=%0d expected err=1 cnt=0", err, wr_count);
        end
        checks++;
        rden = 1'b1; address2 = 32'd12321;
        tick();
        rden = 1'b0;
        if (dataout !== '0 || rd_valid !== 1'b1 || err !== 1'b1) begin
            failures++; $display("FAIL range_read: got %h v=%b err=%b expected 0 v=1 err=1", dataout, rd_valid, err);
        end
        checks++;
    endtask

    task automatic test_swap_collision();
        wren = 1'b1; address1 = 32'd7; wr_mask = 8'hFF; datain = ramp(16'h0700);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        if (wr_count !== 32'd1) begin
            failures++; $display("FAIL coll_count_mid: got %0d expected 1", wr_count);
        end
        checks++;
        datain = ramp(16'h0780);
        tick();
        wren = 1'b0;
        if (sel !== 1'b1 || swap_ack !== 1'b1 || wr_count !== 32'd0) begin
            failures++; $display("FAIL coll_swap: got sel=%b ack=%b cnt=%0d expected sel=1 ack=1 cnt=0", sel, swap_ack, wr_count);
        end
        checks++;
        rden = 1'b1; address2 = 32'd7;
        tick();
        rden = 1'b0;
        if (dataout !== ramp(16'h0780)) begin
            failures++; $display("FAIL coll_read: got %h expected %h", dataout, ramp(16'h0780));
        end
        checks++;
        tick();
        if (swap_ack !== 1'b0) begin
            failures++; $display("FAIL coll_ack_pulse: got %b expected 0", swap_ack);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int acks;
        logic sel0;
        for (int k = 0; k < 4; k++) do_write(AW'(k), 8'hFF, ramp(16'hB000 + DW'(k * 16)));
        do_swap();
        rden = 1'b1;
        for (int k = 0; k < 4; k++) begin
            address2 = AW'(k);
            tick();
            if (rd_valid !== 1'b1 || dataout !== ramp(16'hB000 + DW'(k * 16))) begin
                failures++; $display("FAIL b2b_read%0d: got %h v=%b expected %h v=1",
                                     k, dataout, rd_valid, ramp(16'hB000 + DW'(k * 16)));
            end
            checks++;
        end
        rden = 1'b0;
        tick();
        if (rd_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_valid_drop: got %b expected 0", rd_valid);
        end
        checks++;
        sel0 = sel;
        acks = 0;
        swap_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) swap_req = 1'b0;
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        if (acks != 2 || sel !== sel0) begin
            failures++; $display("FAIL b2b_swaps: got acks=%0d sel=%b expected acks=2 sel=%b", acks, sel, sel0);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_swap();
        do_write(32'd9, 8'h01, {CH{16'hC0DE}});
        swap_req = 1'b1; rden = 1'b1; address2 = 32'd5;
        tick();
        swap_req = 1'b0; rden = 1'b0;
        if (rd_valid !== 1'b1 || sel !== 1'b1 || wr_count !== 32'd1) begin
            failures++; $display("FAIL rmid_pre: got v=%b sel=%b cnt=%0d expected v=1 sel=1 cnt=1", rd_valid, sel, wr_count);
        end
        checks++;
        rst = 1'b0;
        #1;
        if ({dataout, rd_valid, swap_ack, sel, wr_count, err} !== '0) begin
            failures++;
            $display("FAIL rmid_async: got dout=%h v=%b ack=%b sel=%b cnt=%0d err=%b expected all zero",
                     dataout, rd_valid, swap_ack, sel, wr_count, err);
        end
        checks++;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        if (sel !== 1'b0 || swap_ack !== 1'b0) begin
            failures++; $display("FAIL rmid_release: got sel=%b ack=%b expected sel=0 ack=0", sel, swap_ack);
        end
        checks++;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; wren = 1'b0; wr_mask = '0; address1 = '0; datain = '0;
        rden = 1'b0; address2 = '0; swap_req = 1'b0;
        test_reset();
        test_write_swap_read();
        test_mask();
        test_range();
        test_swap_collision();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
